exibe_jogada_leds: RTL and testbench

//   Timed display stage directly upstream of the RGB colour decoder. On a start

---
 rtl/exibe_jogada_leds.sv | 105 ++++++++++
 tb/tb_exibe_jogada_leds.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exibe_jogada_leds.sv
// exibe_jogada_leds: shows a captured one-hot code for T_ACESO cycles, blanks for T_APAGADO, then pulses fim.
// Optional one-hot validation of codigo_in at start (port erro_codigo): define CORES_VALIDA_EN.
module exibe_jogada_leds #(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] codigo_in,
   output logic [3:0] codigo_out,
   output logic       ocupado,
`ifdef CORES_VALIDA_EN
   output logic       erro_codigo,
`endif
   output logic       fim
);

   localparam int MAXT = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
   localparam int CW   = $clog2(MAXT) + 1;
   localparam logic [CW-1:0] ULT_ACESO   = CW'(T_ACESO - 1);
   localparam logic [CW-1:0] ULT_APAGADO = (T_APAGADO > 0) ? CW'(T_APAGADO - 1) : '0;

   typedef enum logic [1:0] {OCIOSO, ACESO, APAGADO, FIM} estado_t;

   estado_t       estado, estado_prox;
   logic [CW-1:0] cnt;
   logic [3:0]    codigo;
   logic          captura;

`ifdef CORES_VALIDA_EN
   logic rejeita;
   logic erro_r;

   function automatic logic eh_one_hot(input logic [3:0] c);
      return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
   endfunction
`endif

   always_comb begin
      estado_prox = estado;
      captura     = 1'b0;
`ifdef CORES_VALIDA_EN
      rejeita     = 1'b0;
`endif
      case (estado)
         OCIOSO, FIM: begin
            if (estado == FIM) estado_prox = OCIOSO;
            // A start is accepted in FIM as well, giving back-to-back playback.
            if (iniciar) begin
`ifdef CORES_VALIDA_EN
               if (eh_one_hot(codigo_in)) begin
                  estado_prox = ACESO;
                  captura     = 1'b1;
               end else begin
                  estado_prox = OCIOSO;
                  rejeita     = 1'b1;
               end
`else
               estado_prox = ACESO;
               captura     = 1'b1;
`endif
            end
         end
         ACESO: begin
            if (cnt == ULT_ACESO) begin
               if (T_APAGADO == 0) estado_prox = FIM;
               else                estado_prox = APAGADO;
            end
         end
         APAGADO: begin
            if (cnt == ULT_APAGADO) estado_prox = FIM;
         end
         default: estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= OCIOSO;
         cnt    <= '0;
         codigo <= 4'd0;
`ifdef CORES_VALIDA_EN
         erro_r <= 1'b0;
`endif
      end else begin
         estado <= estado_prox;
         // Counter restarts at every phase change so each phase counts from zero.
         if (estado_prox != estado)                 cnt <= '0;
         else if (estado == ACESO || estado == APAGADO) cnt <= cnt + CW'(1);
         if (captura) codigo <= codigo_in;
`ifdef CORES_VALIDA_EN
         erro_r <= rejeita;
`endif
      end
   end

   assign codigo_out = (estado == ACESO) ? codigo : 4'd0;
   assign ocupado    = (estado == ACESO) || (estado == APAGADO);
   assign fim        = (estado == FIM);
`ifdef CORES_VALIDA_EN
   assign erro_codigo = erro_r;
`endif

endmodule

// File: tb/tb_exibe_jogada_leds.sv
// Directed bench for exibe_jogada_leds: instance a (T_ACESO=4, T_APAGADO=2), instance b (T_ACESO=4, T_APAGADO=0).
module tb_exibe_jogada_leds;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] codigo_in;
   logic [3:0] codigo_a, codigo_b;
   logic       ocupado_a, ocupado_b;
   logic       fim_a, fim_b;
`ifdef CORES_VALIDA_EN
   logic       erro_a, erro_b;
`endif

   int checks = 0;
   int erros  = 0;

   exibe_jogada_leds #(.T_ACESO(4), .T_APAGADO(2)) dut_a (
      .clock      (clock),
      .reset      (reset),
      .iniciar    (iniciar),
      .codigo_in  (codigo_in),
      .codigo_out (codigo_a),
      .ocupado    (ocupado_a),
`ifdef CORES_VALIDA_EN
      .erro_codigo(erro_a),
`endif
      .fim        (fim_a)
   );

   exibe_jogada_leds #(.T_ACESO(4), .T_APAGADO(0)) dut_b (
      .clock      (clock),
      .reset      (reset),
      .iniciar    (iniciar),
      .codigo_in  (codigo_in),
      .codigo_out (codigo_b),
      .ocupado    (ocupado_b),
`ifdef CORES_VALIDA_EN
      .erro_codigo(erro_b),
`endif
      .fim        (fim_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         erros++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic inicia(input logic [3:0] cod);
      iniciar   = 1'b1;
      codigo_in = cod;
      tick();
      iniciar   = 1'b0;
   endtask

   task automatic verifica_a(input string tag, input int c, input logic [3:0] cod,
                             input logic ocup, input logic f);
      verifica($sformatf("%s cyc%0d codigo_a", tag, c), 32'(codigo_a), 32'(cod));
      verifica($sformatf("%s cyc%0d ocupado_a", tag, c), 32'(ocupado_a), 32'(ocup));
      verifica($sformatf("%s cyc%0d fim_a", tag, c), 32'(fim_a), 32'(f));
   endtask

   task automatic verifica_b(input string tag, input int c, input logic [3:0] cod,
                             input logic ocup, input logic f);
      verifica($sformatf("%s cyc%0d codigo_b", tag, c), 32'(codigo_b), 32'(cod));
      verifica($sformatf("%s cyc%0d ocupado_b", tag, c), 32'(ocupado_b), 32'(ocup));
      verifica($sformatf("%s cyc%0d fim_b", tag, c), 32'(fim_b), 32'(f));
   endtask

   initial begin
      reset     = 1'b0;
      iniciar   = 1'b0;
      codigo_in = 4'd0;
      #2;

      // 1: reset overrides a simultaneous start
      reset     = 1'b1;
      iniciar   = 1'b1;
      codigo_in = 4'b0100;
      tick();
      reset   = 1'b0;
      iniciar = 1'b0;
      verifica_a("reset", 1, 4'b0000, 1'b0, 1'b0);
      verifica_b("reset", 1, 4'b0000, 1'b0, 1'b0);
`ifdef CORES_VALIDA_EN
      verifica("reset erro_a", 32'(erro_a), 32'd0);
`endif
      tick();
      verifica_a("reset idle", 2, 4'b0000, 1'b0, 1'b0);

      // 2: basic display, both instances
      inicia(4'b0100);
      for (int c = 1; c <= 8; c++) begin
         verifica_a("basico", c, (c <= 4) ? 4'b0100 : 4'b0000, c <= 6, c == 7);
         verifica_b("basico", c, (c <= 4) ? 4'b0100 : 4'b0000, c <= 4, c == 5);
`ifdef CORES_VALIDA_EN
         verifica($sformatf("basico cyc%0d erro_a", c), 32'(erro_a), 32'd0);
`endif
         tick();
      end

      // 3: iniciar and codigo_in changes during display are ignored
      inicia(4'b1000);
      for (int c = 1; c <= 8; c++) begin
         if (c == 2) begin
            iniciar   = 1'b1;
            codigo_in = 4'b0001;
         end else begin
            iniciar = 1'b0;
         end
         verifica_a("ignora", c, (c <= 4) ? 4'b1000 : 4'b0000, c <= 6, c == 7);
         tick();
      end
      iniciar = 1'b0;
      repeat (6) tick();

      // 4: reset mid-display blanks with no fim
      inicia(4'b0010);
      for (int c = 1; c <= 10; c++) begin
         reset = (c == 2);
         verifica_a("reset meio", c, (c <= 2) ? 4'b0010 : 4'b0000, c <= 2, 1'b0);
         tick();
      end
      reset = 1'b0;

      // 5: back-to-back start during FIM
      inicia(4'b0001);
      for (int c = 1; c <= 12; c++) begin
         if (c == 7) begin
            iniciar   = 1'b1;
            codigo_in = 4'b0010;
         end else begin
            iniciar = 1'b0;
         end
         verifica_a("encadeado", c,
                    (c <= 4) ? 4'b0001 : ((c >= 8 && c <= 11) ? 4'b0010 : 4'b0000),
                    (c <= 6) || (c >= 8), c == 7);
         tick();
      end
      iniciar = 1'b0;
      repeat (10) tick();

      // 5b: T_APAGADO=0, back-to-back at b's FIM (a is in its gap and ignores it)
      inicia(4'b0001);
      for (int c = 1; c <= 11; c++) begin
         if (c == 5) begin
            iniciar   = 1'b1;
            codigo_in = 4'b0010;
         end else begin
            iniciar = 1'b0;
         end
         verifica_b("sem gap", c,
                    (c <= 4) ? 4'b0001 : ((c >= 6 && c <= 9) ? 4'b0010 : 4'b0000),
                    (c <= 4) || (c >= 6 && c <= 9), (c == 5) || (c == 10));
         verifica_a("sem gap", c, (c <= 4) ? 4'b0001 : 4'b0000, c <= 6, c == 7);
         tick();
      end
      iniciar = 1'b0;
      repeat (10) tick();

      // 6: code that is not one-hot
      inicia(4'b0110);
`ifdef CORES_VALIDA_EN
      verifica("invalido cyc1 erro_a", 32'(erro_a), 32'd1);
      verifica_a("invalido", 1, 4'b0000, 1'b0, 1'b0);
      tick();
      verifica("invalido cyc2 erro_a", 32'(erro_a), 32'd0);
      verifica_a("invalido", 2, 4'b0000, 1'b0, 1'b0);
`else
      for (int c = 1; c <= 5; c++) begin
         verifica_a("invalido", c, (c <= 4) ? 4'b0110 : 4'b0000, c <= 6, 1'b0);
         tick();
      end
`endif
      repeat (10) tick();
      verifica_a("final", 0, 4'b0000, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, erros);
      $finish;
   end

endmodule
